// File: rtl/seq_mul8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul8_ctrl
// Brief    : 8x8 unsigned multiplier built from one shared 4x4 array
//            multiplier, sequenced over four partial-product steps.
// Revision : 1.0
// ============================================================================

// 4x4 unsigned combinational array multiplier: each row adds one
// AND-gated, shifted copy of x selected by one bit of y.
module mul4x4_array (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  always_comb begin
    p = 8'd0;
    for (int i = 0; i < 4; i++) begin
      p = p + ({4'd0, x & {4{y[i]}}} << i);
    end
  end

endmodule

module seq_mul8_ctrl #(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] product_q, product_d;

  logic [3:0]  mul_x;
  logic [3:0]  mul_y;
  logic [7:0]  mul_p;
  logic [3:0]  shamt;
  logic [15:0] pp_shifted;
  logic [15:0] acc_sum;

  // Step bit 0 selects the high nibble of a, step bit 1 the high nibble of b,
  // giving the order lo*lo, hi*lo, lo*hi, hi*hi.
  always_comb begin
    mul_x = step_q[0] ? a_q[7:4] : a_q[3:0];
    mul_y = step_q[1] ? b_q[7:4] : b_q[3:0];
    case (step_q)
      2'd0:    shamt = 4'd0;
      2'd3:    shamt = 4'd8;
      default: shamt = 4'd4;
    endcase
  end

  mul4x4_array u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (mul_p)
  );

  // The full 8x8 product fits in 16 bits, so the accumulator cannot overflow.
  always_comb begin
    pp_shifted = {8'd0, mul_p} << shamt;
    acc_sum    = acc_q + pp_shifted;
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          acc_d  = 16'd0;
          step_d = 2'd0;
          if (EARLY_ZERO && ((a == 8'd0) || (b == 8'd0))) begin
            product_d = 16'd0;
            state_d   = DONE;
          end else begin
            state_d = MUL;
          end
        end
      end

      MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          product_d = acc_sum;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      acc_q     <= 16'd0;
      product_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == MUL);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
`default_nettype wire
